// File: rtl/parking_sensor_driver.sv
// Transmitter for the lot's a/b photo-sensor pair: plays one enter or exit
// obstruction sequence per request, each phase held for dwell+1 cycles.
module parking_sensor_driver #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_enter,
    input  logic               start_exit,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done,
    output logic               dir
);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        P2,
        P3,
        DONE
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] reload;

    // Sensor pattern {a,b} for a phase; exit mirrors enter, P2 is shared.
    function automatic logic [1:0] pattern(input state_t s, input logic x);
        logic [1:0] p;
        p = 2'b00;
        case (s)
            P1:      p = x ? 2'b01 : 2'b10;
            P2:      p = 2'b11;
            P3:      p = x ? 2'b10 : 2'b01;
            default: p = 2'b00;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            reload <= '0;
            a      <= 1'b0;
            b      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dir    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_enter || start_exit) begin
                        state    <= P1;
                        dir      <= start_exit & ~start_enter;
                        reload   <= dwell;
                        cnt      <= dwell;
                        {a, b}   <= pattern(P1, start_exit & ~start_enter);
                        busy     <= 1'b1;
                    end
                    done <= 1'b0;
                end
                P1, P2, P3: begin
                    if (abort) begin
                        state  <= IDLE;
                        {a, b} <= 2'b00;
                        busy   <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (state == P3) begin
                        state  <= DONE;
                        cnt    <= reload;
                        {a, b} <= 2'b00;
                        done   <= 1'b1;
                    end else begin
                        state  <= (state == P1) ? P2 : P3;
                        cnt    <= reload;
                        {a, b} <= pattern((state == P1) ? P2 : P3, dir);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    {a, b} <= 2'b00;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_sensor_driver.sv
// Directed bench for parking_sensor_driver; compares {a,b,busy,done,dir}
// one cycle at a time against hand-derived waveforms.
module tb_parking_sensor_driver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_enter;
    logic       start_exit;
    logic       abort;
    logic [7:0] dwell;
    logic       a, b, busy, done, dir;

    int n_checks = 0;
    int n_fail   = 0;

    parking_sensor_driver #(.DWELL_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_enter (start_enter),
        .start_exit  (start_exit),
        .abort       (abort),
        .dwell       (dwell),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .dir         (dir)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // exp packs {a,b,busy,done,dir}
    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {a, b, busy, done, dir};
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        start_enter = 1'b0;
        start_exit  = 1'b0;
        abort       = 1'b0;
        dwell       = 8'd0;
        #12;
        chk("in_reset", 5'b00000);
        reset_n = 1'b1;
        repeat (4) begin
            step();
            chk("idle", 5'b00000);
        end

        // enter, dwell 0
        start_enter = 1'b1;
        step();
        start_enter = 1'b0;
        chk("en0_p1", 5'b10100);
        step(); chk("en0_p2", 5'b11100);
        step(); chk("en0_p3", 5'b01100);
        step(); chk("en0_done", 5'b00110);
        step(); chk("en0_idle", 5'b00000);

        // exit, dwell 2; dwell changed after acceptance must not matter
        dwell      = 8'd2;
        start_exit = 1'b1;
        step();
        start_exit = 1'b0;
        dwell      = 8'd0;
        chk("ex2_p1", 5'b01101);
        repeat (2) begin step(); chk("ex2_p1", 5'b01101); end
        repeat (3) begin step(); chk("ex2_p2", 5'b11101); end
        repeat (3) begin step(); chk("ex2_p3", 5'b10101); end
        step(); chk("ex2_done", 5'b00111);
        step(); chk("ex2_idle", 5'b00001);

        // both starts: enter wins; exit pulse in P2 ignored
        start_enter = 1'b1;
        start_exit  = 1'b1;
        step();
        start_enter = 1'b0;
        start_exit  = 1'b0;
        chk("both_p1", 5'b10100);
        step(); chk("both_p2", 5'b11100);
        start_exit = 1'b1;
        step();
        start_exit = 1'b0;
        chk("both_p3", 5'b01100);
        step(); chk("both_done", 5'b00110);
        // start sampled at the edge ending DONE is dropped
        start_enter = 1'b1;
        step(); chk("done_start_ignored", 5'b00000);
        step(); chk("first_idle_accept", 5'b10100);
        start_enter = 1'b0;
        step(); chk("acc_p2", 5'b11100);
        step(); chk("acc_p3", 5'b01100);
        step(); chk("acc_done", 5'b00110);
        step(); chk("acc_idle", 5'b00000);
        step(); chk("no_second_seq", 5'b00000);

        // exit dwell 3, abort in second P2 cycle; dir holds
        dwell      = 8'd3;
        start_exit = 1'b1;
        step();
        start_exit = 1'b0;
        chk("ab_p1", 5'b01101);
        repeat (3) begin step(); chk("ab_p1", 5'b01101); end
        step(); chk("ab_p2a", 5'b11101);
        step(); chk("ab_p2b", 5'b11101);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_idle", 5'b00001);
        repeat (3) begin step(); chk("ab_no_done", 5'b00001); end

        // abort+start in IDLE: start accepted; abort in DONE ignored
        dwell       = 8'd0;
        start_enter = 1'b1;
        abort       = 1'b1;
        step();
        start_enter = 1'b0;
        abort       = 1'b0;
        chk("ab_start_p1", 5'b10100);
        step(); chk("ab_start_p2", 5'b11100);
        step(); chk("ab_start_p3", 5'b01100);
        step(); chk("ab_start_done", 5'b00110);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_start_idle", 5'b00000);

        // async reset in the middle of P3
        dwell      = 8'd2;
        start_exit = 1'b1;
        step();
        start_exit = 1'b0;
        chk("rst_p1", 5'b01101);
        repeat (5) step();
        chk("rst_p2_end", 5'b11101);
        step(); chk("rst_p3", 5'b10101);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async", 5'b00000);
        step(); chk("rst_held", 5'b00000);
        #2;
        reset_n = 1'b1;
        repeat (3) begin step(); chk("rst_after", 5'b00000); end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
